// File: rtl/soc_pkg.sv
// Shared SoC constants for the pushbutton peripheral: register offsets,
// bit positions inside the bus words, counter widths, and a saturating
// adder used by the press counter.
package soc_pkg;

   // Register offsets (one address bit selects the register)
   localparam logic BTN_STATUS_ADDR = 1'b0;
   localparam logic BTN_COUNT_ADDR  = 1'b1;

   // Bit positions inside the 32-bit bus words
   localparam int BTN_PENDING_LSB = 8;
   localparam int BTN_MASK_LSB    = 16;

   // 20 ms at 50 MHz
   localparam int BTN_DEBOUNCE_CYCLES = 1000000;

   // Debounce counter width and press counter width
   localparam int BTN_CNT_W   = 24;
   localparam int BTN_PRESS_W = 16;

   localparam logic [BTN_PRESS_W-1:0] BTN_PRESS_MAX = '1;

   // Adds up to 255 to the press counter, clamping at all-ones.
   function automatic logic [BTN_PRESS_W-1:0] btn_sat_add(
      input logic [BTN_PRESS_W-1:0] base,
      input logic [7:0]             inc
   );
      logic [BTN_PRESS_W:0] sum;
      sum = {1'b0, base} + {{(BTN_PRESS_W-7){1'b0}}, inc};
      return sum[BTN_PRESS_W] ? BTN_PRESS_MAX : sum[BTN_PRESS_W-1:0];
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: two-flop synchroniser on the raw active-low pin, a
// stability counter, the accepted level (1 = pressed) and a one-cycle
// combinational press strobe that is high in the cycle whose closing
// edge moves the level from 0 to 1.
module button_debounce
   import soc_pkg::*;
#(
   // Legal range 2 .. 2^24-1
   parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic button_n,
   output logic level,
   output logic press
);

   localparam logic [BTN_CNT_W-1:0] CNT_LAST = BTN_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic                 level_q, level_d;
   logic [BTN_CNT_W-1:0] cnt_q,   cnt_d;
   logic                 sync;
   logic                 accept;

   // Synchroniser stages simply shift the raw pin along
   always_comb begin
      sync1_d = button_n;
      sync2_d = sync1_q;
   end

   // Inverted so that downstream logic sees 1 = pressed
   assign sync = ~sync2_q;

   // Stability counter: any disagreement restarts the count once it ends
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      accept  = 1'b0;
      if (sync == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         accept  = 1'b1;
         level_d = sync;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Synchroniser flops reset to "released" so a held button re-debounces
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   // Only a 0->1 acceptance is a press; releases are silent
   assign press = accept & sync;

endmodule

// File: rtl/button_input_reg.sv
// Memory-mapped pushbutton peripheral. Debounces WIDTH active-low pins,
// latches press events in a write-1-to-clear STATUS register and counts
// presses in a saturating 16-bit COUNT register (any write clears it).
// Optional feature macro: BUTTON_IRQ_EN adds a write-only IRQ mask
// (written with COUNT at wdata[18:16]) and a registered irq output.
module button_input_reg
   import soc_pkg::*;
#(
   parameter int WIDTH           = 3,
   parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] button,
   input  logic             select,
   input  logic             write,
   input  logic             address,
   input  logic [31:0]      wdata,
`ifdef BUTTON_IRQ_EN
   output logic             irq,
`endif
   output logic [31:0]      rdata
);

   logic [WIDTH-1:0]       level_w;
   logic [WIDTH-1:0]       press_w;

   logic [WIDTH-1:0]       pending_q, pending_d;
   logic [BTN_PRESS_W-1:0] presses_q, presses_d;
   logic [31:0]            rdata_q,   rdata_d;

   logic                   wr_status;
   logic                   wr_count;
   logic                   rd_access;
   logic [WIDTH-1:0]       pending_clr;
   logic [7:0]             press_cnt;
   logic [31:0]            status_word;
   logic [31:0]            count_word;
   logic                   wdata_unused;

   // Only some wdata bits carry meaning; the rest are intentionally ignored
   assign wdata_unused = ^wdata;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_btn
         button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clock   (clock),
            .reset   (reset),
            .button_n(button[gi]),
            .level   (level_w[gi]),
            .press   (press_w[gi])
         );
      end
   endgenerate

   // Bus decode
   always_comb begin
      wr_status = select & write & (address == BTN_STATUS_ADDR);
      wr_count  = select & write & (address == BTN_COUNT_ADDR);
      rd_access = select & ~write;
   end

   // Pending bits: clear first, then OR in new events so a set wins a race
   always_comb begin
      pending_clr = '0;
      if (wr_status) begin
         pending_clr = wdata[BTN_PENDING_LSB +: WIDTH];
      end
      pending_d = (pending_q & ~pending_clr) | press_w;
   end

   // Press counter: a COUNT write zeroes the base, same-cycle events still add
   always_comb begin
      press_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         press_cnt = press_cnt + 8'(press_w[i]);
      end
      presses_d = btn_sat_add(wr_count ? '0 : presses_q, press_cnt);
   end

   // Read mux works on pre-edge state, so reads see pre-event values
   always_comb begin
      status_word                              = '0;
      status_word[WIDTH-1:0]                   = level_w;
      status_word[BTN_PENDING_LSB +: WIDTH]    = pending_q;
      count_word                               = {{(32-BTN_PRESS_W){1'b0}}, presses_q};
      rdata_d                                  = rdata_q;
      if (rd_access) begin
         rdata_d = (address == BTN_COUNT_ADDR) ? count_word : status_word;
      end
   end

   // Register file state
   always_ff @(posedge clock) begin
      if (reset) begin
         pending_q <= '0;
         presses_q <= '0;
         rdata_q   <= '0;
      end else begin
         pending_q <= pending_d;
         presses_q <= presses_d;
         rdata_q   <= rdata_d;
      end
   end

   assign rdata = rdata_q;

`ifdef BUTTON_IRQ_EN
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             irq_q,  irq_d;

   // Mask rides along with the COUNT write; irq lags pending by one edge
   always_comb begin
      mask_d = mask_q;
      if (wr_count) begin
         mask_d = wdata[BTN_MASK_LSB +: WIDTH];
      end
      irq_d = |(pending_q & mask_q);
   end

   // Interrupt mask and output register
   always_ff @(posedge clock) begin
      if (reset) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         irq_q  <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_button_input_reg.sv
// Directed bench for button_input_reg with DEBOUNCE_CYCLES = 4.
module tb_button_input_reg;

   localparam int W  = 3;
   localparam int DB = 4;

   localparam logic [1:0] OP_NOP = 2'd0;
   localparam logic [1:0] OP_RD  = 2'd1;
   localparam logic [1:0] OP_WR  = 2'd2;

   logic          clock   = 1'b0;
   logic          reset   = 1'b1;
   logic [W-1:0]  button  = '1;
   logic          select  = 1'b0;
   logic          write   = 1'b0;
   logic          address = 1'b0;
   logic [31:0]   wdata   = '0;
   logic [31:0]   rdata;
`ifdef BUTTON_IRQ_EN
   logic          irq;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   button_input_reg #(
      .WIDTH          (W),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .button (button),
      .select (select),
      .write  (write),
      .address(address),
      .wdata  (wdata),
`ifdef BUTTON_IRQ_EN
      .irq    (irq),
`endif
      .rdata  (rdata)
   );

   typedef struct {
      logic [W-1:0] btn;
      int           wait_cyc;
      logic [1:0]   op;
      logic         addr;
      logic [31:0]  wd;
      logic [31:0]  exp;
   } vec_t;

   vec_t vecs[17];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic bus_read(input logic a);
      select  = 1'b1;
      write   = 1'b0;
      address = a;
      tick();
      select  = 1'b0;
   endtask

   task automatic bus_write(input logic a, input logic [31:0] d);
      select  = 1'b1;
      write   = 1'b1;
      address = a;
      wdata   = d;
      tick();
      select  = 1'b0;
      write   = 1'b0;
      wdata   = '0;
   endtask

   initial begin
      // Table entered with button[0] held, level=001, pending=001, presses=1,
      // and the last read returning STATUS 0x101.
      vecs[0]  = '{3'b110,  0, OP_WR,  1'b1, 32'h0000_0000, 32'h0000_0101};
      vecs[1]  = '{3'b110,  0, OP_RD,  1'b1, 32'h0,         32'h0000_0000};
      vecs[2]  = '{3'b010, 10, OP_RD,  1'b0, 32'h0,         32'h0000_0505};
      vecs[3]  = '{3'b010,  0, OP_RD,  1'b1, 32'h0,         32'h0000_0001};
      vecs[4]  = '{3'b000, 10, OP_RD,  1'b0, 32'h0,         32'h0000_0707};
      vecs[5]  = '{3'b000,  0, OP_RD,  1'b1, 32'h0,         32'h0000_0002};
      vecs[6]  = '{3'b000,  3, OP_NOP, 1'b0, 32'h0,         32'h0000_0002};
      vecs[7]  = '{3'b000,  0, OP_WR,  1'b0, 32'h0000_0400, 32'h0000_0002};
      vecs[8]  = '{3'b000,  0, OP_RD,  1'b0, 32'h0,         32'h0000_0307};
      vecs[9]  = '{3'b000,  0, OP_WR,  1'b0, 32'hFFFF_F8FF, 32'h0000_0307};
      vecs[10] = '{3'b000,  0, OP_RD,  1'b0, 32'h0,         32'h0000_0307};
      vecs[11] = '{3'b111, 10, OP_RD,  1'b0, 32'h0,         32'h0000_0300};
      vecs[12] = '{3'b111,  0, OP_RD,  1'b1, 32'h0,         32'h0000_0002};
      vecs[13] = '{3'b111,  0, OP_WR,  1'b1, 32'h0004_5678, 32'h0000_0002};
      vecs[14] = '{3'b111,  0, OP_RD,  1'b1, 32'h0,         32'h0000_0000};
      vecs[15] = '{3'b111,  0, OP_WR,  1'b0, 32'h0000_0700, 32'h0000_0000};
      vecs[16] = '{3'b111,  0, OP_RD,  1'b0, 32'h0,         32'h0000_0000};

      // Reset read
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      check("rst_rdata", rdata, 32'h0);
`ifdef BUTTON_IRQ_EN
      check("rst_irq", {31'b0, irq}, 32'h0);
`endif
      bus_read(1'b0);
      check("rst_status", rdata, 32'h0);
      bus_read(1'b1);
      check("rst_count", rdata, 32'h0);

      // Clean press: pin low before edge 1, level updates at edge 6,
      // so the read sampled at edge 7 is the first to see it.
      button[0] = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         bus_read(1'b0);
         check($sformatf("press_t%0d", k), rdata, (k < 7) ? 32'h0 : 32'h101);
      end
      bus_read(1'b1);
      check("press_count", rdata, 32'h1);

      // Release: level drops with the same latency, pending stays
      button[0] = 1'b1;
      for (int k = 6; k <= 7; k++) begin
         if (k == 6) repeat (5) tick();
         bus_read(1'b0);
         check($sformatf("release_t%0d", k), rdata, (k < 7) ? 32'h101 : 32'h100);
      end

      // Glitch of 3 cycles on button[1] is rejected
      button[1] = 1'b0;
      repeat (3) tick();
      button[1] = 1'b1;
      repeat (10) tick();
      bus_read(1'b0);
      check("glitch_status", rdata, 32'h100);
      bus_read(1'b1);
      check("glitch_count", rdata, 32'h1);

      // Clear, then race a clear against a new press on the same edge
      bus_write(1'b0, 32'h100);
      bus_read(1'b0);
      check("clear_status", rdata, 32'h0);
      button[0] = 1'b0;
      repeat (5) tick();
      bus_write(1'b0, 32'h100);
      bus_read(1'b0);
      check("race_set_wins", rdata, 32'h101);
      bus_write(1'b0, 32'h100);
      bus_read(1'b0);
      check("race_second_clear", rdata, 32'h001);
      bus_read(1'b1);
      check("race_count", rdata, 32'h2);

      // COUNT clear racing a press: result is 1
      button[0] = 1'b1;
      repeat (10) tick();
      button[0] = 1'b0;
      repeat (5) tick();
      bus_write(1'b1, 32'h0);
      bus_read(1'b1);
      check("count_race", rdata, 32'h1);
      bus_read(1'b0);
      check("count_race_status", rdata, 32'h101);

      // Table-driven register vectors
      for (int i = 0; i < 17; i++) begin
         button = vecs[i].btn;
         repeat (vecs[i].wait_cyc) tick();
         case (vecs[i].op)
            OP_RD:   bus_read(vecs[i].addr);
            OP_WR:   bus_write(vecs[i].addr, vecs[i].wd);
            default: tick();
         endcase
         check($sformatf("vec%0d", i), rdata, vecs[i].exp);
      end

      // Two simultaneous presses add 2
      button = 3'b100;
      repeat (10) tick();
      bus_read(1'b1);
      check("simul_count", rdata, 32'h2);
      button = 3'b111;
      repeat (10) tick();
      bus_read(1'b0);
      check("simul_status", rdata, 32'h300);
      bus_write(1'b0, 32'h700);

      // Saturation: preload 0xFFFE, two presses clamp to 0xFFFF
      force dut.presses_q = 16'hFFFE;
      #1;
      release dut.presses_q;
      button = 3'b100;
      repeat (10) tick();
      bus_read(1'b1);
      check("sat_clamp", rdata, 32'hFFFF);
      button = 3'b111;
      repeat (10) tick();
      button = 3'b011;
      repeat (10) tick();
      bus_read(1'b1);
      check("sat_hold", rdata, 32'hFFFF);
      button = 3'b111;
      repeat (10) tick();
      bus_write(1'b1, 32'h0);
      bus_read(1'b1);
      check("sat_clear", rdata, 32'h0);

      // Reset in the middle of a debounce with buttons still held
      button[2] = 1'b0;
      repeat (10) tick();
      bus_read(1'b1);
      check("pre_reset_count", rdata, 32'h1);
      button[1] = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_rdata", rdata, 32'h0);
`ifdef BUTTON_IRQ_EN
      check("midrst_irq", {31'b0, irq}, 32'h0);
`endif
      for (int k = 1; k <= 7; k++) begin
         bus_read(1'b0);
         if (k >= 6) check($sformatf("midrst_t%0d", k), rdata, (k < 7) ? 32'h0 : 32'h606);
      end
      bus_read(1'b1);
      check("midrst_count", rdata, 32'h2);

`ifdef BUTTON_IRQ_EN
      // Mask = 001: pending[1], pending[2] do not raise irq
      bus_write(1'b1, 32'h0001_0000);
      tick();
      check("irq_masked", {31'b0, irq}, 32'h0);
      button[0] = 1'b0;
      repeat (6) tick();
      check("irq_pending_edge", {31'b0, irq}, 32'h0);
      tick();
      check("irq_raised", {31'b0, irq}, 32'h1);
      bus_write(1'b0, 32'h100);
      check("irq_clear_edge", {31'b0, irq}, 32'h1);
      tick();
      check("irq_dropped", {31'b0, irq}, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
